// File: rtl/ftdi_fifo_pkg.sv
// Shared state encodings and default timing for the FT245 FIFO controller.
// The state names are referenced hierarchically by benches and debug tools.
package ftdi_fifo_pkg;

    localparam int DEF_WR_BYTES   = 256;
    localparam int DEF_RD_LOW_CYC = 2;
    localparam int DEF_WR_LOW_CYC = 2;

    typedef enum logic [1:0] {
        ST_RDCTRL_IDLE    = 2'd0,
        ST_RDCTRL_LOW     = 2'd1,
        ST_RDCTRL_RECOVER = 2'd2
    } rd_state_e;

    typedef enum logic [2:0] {
        ST_WRCTRL_IDLE  = 3'd0,
        ST_WRCTRL_SETUP = 3'd1,
        ST_WRCTRL_LOW   = 3'd2,
        ST_WRCTRL_HOLD  = 3'd3,
        ST_WRCTRL_DONE  = 3'd4
    } wr_state_e;

endpackage

// File: rtl/ftdi_fifo_ctrl_if.sv
// FT245 pin bundle between the controller (master) and the pad buffer / host model (slave).
interface ftdi_fifo_ctrl_if;
    logic       iFIFO_RXF_n;
    logic       oFIFO_RD_n;
    logic [7:0] iFIFO_DATA;
    logic       iFIFO_TXE_n;
    logic       oFIFO_WR_n;
    logic [7:0] oFIFO_DATA;
    logic       oFIFO_OE_n;

    modport master (
        input  iFIFO_RXF_n, iFIFO_DATA, iFIFO_TXE_n,
        output oFIFO_RD_n, oFIFO_WR_n, oFIFO_DATA, oFIFO_OE_n
    );

    modport slave (
        output iFIFO_RXF_n, iFIFO_DATA, iFIFO_TXE_n,
        input  oFIFO_RD_n, oFIFO_WR_n, oFIFO_DATA, oFIFO_OE_n
    );
endinterface

// File: rtl/ftdi_fifo_sync2.sv
// Two-flop synchronizer for the asynchronous FTDI status flags.
module ftdi_fifo_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;

    // Reset to the inactive level so nothing starts before the flag is really seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/ftdi_fifo_ctrl.sv
// FT245 link tester: streams an incrementing byte pattern to the host and
// verifies that host bytes arrive as a contiguous incrementing sequence.
module ftdi_fifo_ctrl
    import ftdi_fifo_pkg::*;
#(
    parameter int WR_BYTES   = DEF_WR_BYTES,
    parameter int RD_LOW_CYC = DEF_RD_LOW_CYC,
    parameter int WR_LOW_CYC = DEF_WR_LOW_CYC
) (
    input  logic             clk,
    input  logic             rst,
    ftdi_fifo_ctrl_if.master bus,
    output logic             oRD_VERIFY_NG
);
    localparam int CNT_W = $clog2(WR_BYTES + 1);
    localparam int CYC_W = 8;

    logic rxf_n_s, txe_n_s;

    rd_state_e rd_ctrl_state_q, rd_ctrl_state_d, rd_ctrl_state;
    wr_state_e wr_ctrl_state_q, wr_ctrl_state_d, wr_ctrl_state;
    logic [CYC_W-1:0] rd_cyc_q, rd_cyc_d, wr_cyc_q, wr_cyc_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [7:0]       rd_expect_q, rd_expect_d, data_q, data_d;
    logic rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_n_q, oe_n_d, ng_q, ng_d;
    logic bus_free, rd_req, wr_req;

    ftdi_fifo_sync2 u_sync_rxf (.clk(clk), .rst(rst), .d(bus.iFIFO_RXF_n), .q(rxf_n_s));
    ftdi_fifo_sync2 u_sync_txe (.clk(clk), .rst(rst), .d(bus.iFIFO_TXE_n), .q(txe_n_s));

    assign rd_ctrl_state = rd_ctrl_state_q;
    assign wr_ctrl_state = wr_ctrl_state_q;

    // Read wins whenever RXF is pending, so a write may only start when it is not.
    assign bus_free = (wr_ctrl_state == ST_WRCTRL_IDLE) || (wr_ctrl_state == ST_WRCTRL_DONE);
    assign rd_req   = !rxf_n_s && bus_free;
    assign wr_req   = (wr_cnt_q < CNT_W'(WR_BYTES)) && !txe_n_s && rxf_n_s &&
                      (rd_ctrl_state == ST_RDCTRL_IDLE);

    always_comb begin
        rd_ctrl_state_d = rd_ctrl_state_q;
        rd_cyc_d        = rd_cyc_q;
        rd_expect_d     = rd_expect_q;
        ng_d            = ng_q;
        case (rd_ctrl_state_q)
            ST_RDCTRL_IDLE: if (rd_req) begin
                rd_ctrl_state_d = ST_RDCTRL_LOW;
                rd_cyc_d        = '0;
            end
            ST_RDCTRL_LOW: if (rd_cyc_q == CYC_W'(RD_LOW_CYC - 1)) begin
                ng_d            = ng_q | (bus.iFIFO_DATA != rd_expect_q);
                rd_expect_d     = bus.iFIFO_DATA + 8'd1;
                rd_ctrl_state_d = ST_RDCTRL_RECOVER;
                rd_cyc_d        = '0;
            end else begin
                rd_cyc_d = rd_cyc_q + CYC_W'(1);
            end
            ST_RDCTRL_RECOVER: if (rxf_n_s || rd_cyc_q == CYC_W'(1)) begin
                rd_ctrl_state_d = ST_RDCTRL_IDLE;
            end else begin
                rd_cyc_d = rd_cyc_q + CYC_W'(1);
            end
            default: rd_ctrl_state_d = ST_RDCTRL_IDLE;
        endcase
    end

    always_comb begin
        wr_ctrl_state_d = wr_ctrl_state_q;
        wr_cyc_d        = wr_cyc_q;
        wr_cnt_d        = wr_cnt_q;
        case (wr_ctrl_state_q)
            ST_WRCTRL_IDLE:  if (wr_req) wr_ctrl_state_d = ST_WRCTRL_SETUP;
            ST_WRCTRL_SETUP: begin
                wr_ctrl_state_d = ST_WRCTRL_LOW;
                wr_cyc_d        = '0;
            end
            ST_WRCTRL_LOW: if (wr_cyc_q == CYC_W'(WR_LOW_CYC - 1)) begin
                wr_ctrl_state_d = ST_WRCTRL_HOLD;
            end else begin
                wr_cyc_d = wr_cyc_q + CYC_W'(1);
            end
            ST_WRCTRL_HOLD: begin
                wr_cnt_d        = wr_cnt_q + CNT_W'(1);
                wr_ctrl_state_d = (wr_cnt_d == CNT_W'(WR_BYTES)) ? ST_WRCTRL_DONE : ST_WRCTRL_IDLE;
            end
            ST_WRCTRL_DONE:  wr_ctrl_state_d = ST_WRCTRL_DONE;
            default:         wr_ctrl_state_d = ST_WRCTRL_IDLE;
        endcase
    end

    // Pin values are decoded from next state so every output comes straight off a flop.
    always_comb begin
        rd_n_d = (rd_ctrl_state_d != ST_RDCTRL_LOW);
        wr_n_d = (wr_ctrl_state_d != ST_WRCTRL_LOW);
        oe_n_d = !(wr_ctrl_state_d inside {ST_WRCTRL_SETUP, ST_WRCTRL_LOW, ST_WRCTRL_HOLD});
        data_d = (wr_ctrl_state_d == ST_WRCTRL_SETUP) ? 8'(wr_cnt_q) : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ctrl_state_q <= ST_RDCTRL_IDLE;
            wr_ctrl_state_q <= ST_WRCTRL_IDLE;
            rd_cyc_q        <= '0;
            wr_cyc_q        <= '0;
            wr_cnt_q        <= '0;
            rd_expect_q     <= 8'h00;
            data_q          <= 8'h00;
            rd_n_q          <= 1'b1;
            wr_n_q          <= 1'b1;
            oe_n_q          <= 1'b1;
            ng_q            <= 1'b0;
        end else begin
            rd_ctrl_state_q <= rd_ctrl_state_d;
            wr_ctrl_state_q <= wr_ctrl_state_d;
            rd_cyc_q        <= rd_cyc_d;
            wr_cyc_q        <= wr_cyc_d;
            wr_cnt_q        <= wr_cnt_d;
            rd_expect_q     <= rd_expect_d;
            data_q          <= data_d;
            rd_n_q          <= rd_n_d;
            wr_n_q          <= wr_n_d;
            oe_n_q          <= oe_n_d;
            ng_q            <= ng_d;
        end
    end

    assign bus.oFIFO_RD_n = rd_n_q;
    assign bus.oFIFO_WR_n = wr_n_q;
    assign bus.oFIFO_OE_n = oe_n_q;
    assign bus.oFIFO_DATA = data_q;
    assign oRD_VERIFY_NG  = ng_q;
endmodule

// File: tb/tb_ftdi_fifo_ctrl.sv
// Scoreboard bench for ftdi_fifo_ctrl: a host model feeds reads, a monitor
// checks strobes, write data order, verify flag and bus-ownership rules.
module tb_ftdi_fifo_ctrl;
    import ftdi_fifo_pkg::*;

    localparam int WR_BYTES = 256;
    localparam int RD_LOW   = 2;
    localparam int WR_LOW   = 2;

    logic clk = 1'b0;
    logic rst;
    logic ng;

    ftdi_fifo_ctrl_if bus();

    ftdi_fifo_ctrl #(.WR_BYTES(WR_BYTES), .RD_LOW_CYC(RD_LOW), .WR_LOW_CYC(WR_LOW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .oRD_VERIFY_NG(ng)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] host_q[$];
    logic       ng_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] ref_expect;
    logic       ref_ng;
    logic       txe_req;
    int rd_pulses = 0, wr_pulses = 0;
    int first_strobe = 0;
    bit arm_first = 0;
    logic prev_rd_n = 1'b1, prev_oe_n = 1'b1;
    int rd_low = 0, wr_low = 0;
    logic [7:0] wr_hold = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host byte plus the verify outcome the link rules predict for it.
    task automatic host_push(input logic [7:0] b);
        host_q.push_back(b);
        ref_ng     = ref_ng | (b != ref_expect);
        ref_expect = b + 8'd1;
        ng_q.push_back(ref_ng);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_q.delete();
        ng_q.delete();
        wr_q.delete();
        ref_expect = 8'h00;
        ref_ng     = 1'b0;
        txe_req    = 1'b1;
        #1;
        chk("reset_rd_n", bus.oFIFO_RD_n, 1);
        chk("reset_wr_n", bus.oFIFO_WR_n, 1);
        chk("reset_oe_n", bus.oFIFO_OE_n, 1);
        chk("reset_data", bus.oFIFO_DATA, 8'h00);
        chk("reset_ng", ng, 0);
        chk("reset_wr_state", dut.wr_ctrl_state, ST_WRCTRL_IDLE);
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < WR_BYTES; i++) wr_q.push_back(8'(i));
    endtask

    task automatic wait_rd_drain(input int bound);
        int n = 0;
        while ((host_q.size() != 0 || ng_q.size() != 0) && n < bound) begin
            tick(1);
            n++;
        end
        chk("rd_drain_in_time", (n < bound), 1);
        tick(8);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (dut.wr_ctrl_state != ST_WRCTRL_DONE && n < bound) begin
            tick(1);
            n++;
        end
        chk("wr_done_in_time", (n < bound), 1);
    endtask

    // Monitor and host pin driver, both acting on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd_n = 1'b1;
                prev_oe_n = 1'b1;
                rd_low    = 0;
                wr_low    = 0;
            end else begin
                chk("rd_oe_overlap", (!bus.oFIFO_RD_n && !bus.oFIFO_OE_n), 0);
                chk("rd_to_wr_gap", (!bus.oFIFO_OE_n && !prev_rd_n), 0);
                chk("wr_to_rd_gap", (!bus.oFIFO_RD_n && !prev_oe_n), 0);

                if (!bus.oFIFO_RD_n) begin
                    rd_low++;
                end else if (rd_low != 0) begin
                    rd_pulses++;
                    chk("rd_low_width", rd_low, RD_LOW);
                    if (ng_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_unexpected: read strobe with no host byte queued at %0t", $time);
                    end else begin
                        chk("verify_ng", ng, ng_q.pop_front());
                    end
                    if (host_q.size() != 0) void'(host_q.pop_front());
                    rd_low = 0;
                end

                if (!bus.oFIFO_WR_n) begin
                    if (wr_low == 0) wr_hold = bus.oFIFO_DATA;
                    else chk("wr_data_stable", bus.oFIFO_DATA, wr_hold);
                    chk("wr_oe_low", bus.oFIFO_OE_n, 0);
                    wr_low++;
                end else if (wr_low != 0) begin
                    wr_pulses++;
                    chk("wr_low_width", wr_low, WR_LOW);
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_extra: write strobe data 0x%0h beyond pattern at %0t", wr_hold, $time);
                    end else begin
                        chk("wr_data", wr_hold, wr_q.pop_front());
                    end
                    wr_low = 0;
                end

                if (arm_first && first_strobe == 0) begin
                    if (!bus.oFIFO_RD_n) first_strobe = 1;
                    else if (!bus.oFIFO_OE_n) first_strobe = 2;
                end
                prev_rd_n = bus.oFIFO_RD_n;
                prev_oe_n = bus.oFIFO_OE_n;
            end
            bus.iFIFO_RXF_n = (host_q.size() == 0);
            bus.iFIFO_DATA  = (host_q.size() != 0) ? host_q[0] : 8'h00;
            bus.iFIFO_TXE_n = txe_req;
        end
    end

    initial begin
        int rd0, wr0, n;
        logic [7:0] b;
        rst = 1'b0;
        txe_req = 1'b1;
        bus.iFIFO_RXF_n = 1'b1;
        bus.iFIFO_TXE_n = 1'b1;
        bus.iFIFO_DATA  = 8'h00;
        #2;

        // Quiet bus: nothing may happen.
        do_reset();
        rd0 = rd_pulses; wr0 = wr_pulses;
        tick(100);
        chk("idle_rd_pulses", rd_pulses - rd0, 0);
        chk("idle_wr_pulses", wr_pulses - wr0, 0);
        chk("idle_oe_n", bus.oFIFO_OE_n, 1);
        chk("idle_ng", ng, 0);

        // Good read stream.
        rd0 = rd_pulses;
        for (int i = 0; i < 16; i++) host_push(8'(i));
        wait_rd_drain(500);
        chk("good_rd_pulses", rd_pulses - rd0, 16);
        chk("good_rd_ng", ng, 0);

        // Gap in the read stream sets the sticky flag.
        do_reset();
        host_push(8'h00); host_push(8'h01); host_push(8'h05); host_push(8'h06);
        wait_rd_drain(200);
        chk("bad_rd_ng_sticky", ng, 1);

        // Steady write stream.
        do_reset();
        wr0 = wr_pulses;
        txe_req = 1'b0;
        wait_done(4000);
        tick(4);
        chk("wr_stream_pulses", wr_pulses - wr0, WR_BYTES);
        tick(50);
        chk("wr_no_more_pulses", wr_pulses - wr0, WR_BYTES);
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("wr_done_oe_n", bus.oFIFO_OE_n, 1);

        // Read and write requested in the same cycle.
        do_reset();
        tick(5);
        first_strobe = 0;
        arm_first = 1;
        host_push(8'h00);
        txe_req = 1'b0;
        tick(30);
        chk("read_priority", first_strobe, 1);
        arm_first = 0;

        // Async reset in the middle of a write strobe.
        n = 0;
        while (bus.oFIFO_WR_n !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        chk("saw_wr_low", (n < 200), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_wr_n", bus.oFIFO_WR_n, 1);
        chk("async_oe_n", bus.oFIFO_OE_n, 1);
        chk("async_rd_n", bus.oFIFO_RD_n, 1);
        do_reset();
        wr0 = wr_pulses;
        txe_req = 1'b0;
        n = 0;
        while (wr_pulses - wr0 < 3 && n < 200) begin
            tick(1);
            n++;
        end
        chk("restart_writes", (wr_pulses - wr0 >= 3), 1);

        // Random TXE throttling with interleaved host traffic.
        do_reset();
        wr0 = wr_pulses;
        n = 0;
        for (int pushes = 0; dut.wr_ctrl_state != ST_WRCTRL_DONE && n < 20000; n++) begin
            if ($urandom_range(0, 9) == 0) txe_req = ($urandom_range(0, 3) == 0);
            if (pushes < 40 && $urandom_range(0, 30) == 0) begin
                b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : ref_expect;
                host_push(b);
                pushes++;
            end
            tick(1);
        end
        chk("rand_done_in_time", (n < 20000), 1);
        for (int i = 0; i < 3; i++) host_push(8'($urandom_range(0, 255)));
        wait_rd_drain(2000);
        chk("rand_wr_pulses", wr_pulses - wr0, WR_BYTES);
        chk("rand_wr_queue_empty", wr_q.size(), 0);
        chk("rand_ng_model", ng, ref_ng);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
